// File: rtl/bdc_rx_byte_pkg.sv
// Shared BDC definitions: FSM state encoding, default bit-cell timing,
// and the cell-counter width helper used by the receive and transmit sides.
package bdc_rx_byte_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CELL,
    ST_PUSH,
    ST_FIN
  } rx_state_t;

  localparam int unsigned DEF_DIV       = 4;
  localparam int unsigned DEF_START_TC  = 4;
  localparam int unsigned DEF_SAMPLE_TC = 10;
  localparam int unsigned DEF_BIT_TC    = 16;

  // Cell counter width; the extra bit keeps L-1 representable for any L.
  function automatic int unsigned cnt_width(input int unsigned div,
                                            input int unsigned bit_tc);
    return $clog2(bit_tc * div) + 1;
  endfunction

endpackage

// File: rtl/bdc_rx_byte_if.sv
// Byte receiver handshake bundle: command sequencer start/status and rx_fifo push port.
interface bdc_rx_byte_if;
  logic       start;
  logic [3:0] byte_count;
  logic       full;
  logic       put_pulse;
  logic [7:0] put_byte;
  logic       busy;
  logic       done;

  // Environment side (sequencer + FIFO)
  modport master (
    output start, byte_count, full,
    input  put_pulse, put_byte, busy, done
  );

  // Receiver side
  modport slave (
    input  start, byte_count, full,
    output put_pulse, put_byte, busy, done
  );
endinterface

// File: rtl/bdc_rx_byte_bit_timer.sv
// BDC bit-cell timer: cell counter, drive-low window, sample strobe and cell-end strobe.
module bdc_bit_timer
  import bdc_rx_byte_pkg::*;
#(
  parameter int unsigned DIV       = DEF_DIV,
  parameter int unsigned START_TC  = DEF_START_TC,
  parameter int unsigned SAMPLE_TC = DEF_SAMPLE_TC,
  parameter int unsigned BIT_TC    = DEF_BIT_TC
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic drive_low,
  output logic sample,
  output logic cell_end
);

  localparam int unsigned CW = cnt_width(DIV, BIT_TC);
  localparam logic [CW-1:0] C_LAST   = CW'(BIT_TC * DIV - 1);
  localparam logic [CW-1:0] C_OE_END = CW'(START_TC * DIV);
  localparam logic [CW-1:0] C_SAMPLE = CW'(SAMPLE_TC * DIV - 1);

  logic [CW-1:0] c;

  // Cell counter: held at 0 while idle, wraps to 0 after L-1 so the next cell starts at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c <= '0;
    end else if (!run || c == C_LAST) begin
      c <= '0;
    end else begin
      c <= c + CW'(1);
    end
  end

  // Strobes decoded from the counter, all gated by run.
  always_comb begin
    drive_low = run && (c < C_OE_END);
    sample    = run && (c == C_SAMPLE);
    cell_end  = run && (c == C_LAST);
  end

endmodule

// File: rtl/bdc_rx_byte.sv
// BDC single-wire receiver: drives read bit cells on BKGD, samples the target's reply,
// assembles bytes MSB-first and pushes them into rx_fifo, respecting FIFO full.
module bdc_rx_byte
  import bdc_rx_byte_pkg::*;
#(
  parameter int unsigned DIV       = DEF_DIV,
  parameter int unsigned START_TC  = DEF_START_TC,
  parameter int unsigned SAMPLE_TC = DEF_SAMPLE_TC,
  parameter int unsigned BIT_TC    = DEF_BIT_TC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bkgd_in,
  output logic              bkgd_oe,
  bdc_rx_byte_if.slave      bus
);

  rx_state_t  state, state_nxt;
  logic [1:0] bkgd_sync;
  logic       bkgd_s;
  logic [7:0] shreg;
  logic [7:0] last_byte;
  logic [2:0] bit_idx;
  logic [3:0] rem;
  logic       drive_low, sample, cell_end;
  logic       push;

  bdc_bit_timer #(
    .DIV       (DIV),
    .START_TC  (START_TC),
    .SAMPLE_TC (SAMPLE_TC),
    .BIT_TC    (BIT_TC)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .run       (state == ST_CELL),
    .drive_low (drive_low),
    .sample    (sample),
    .cell_end  (cell_end)
  );

  assign bkgd_s = bkgd_sync[1];
  assign push   = (state == ST_PUSH) && !bus.full;

  // Two-flop synchronizer for the asynchronous pad input; idles high like the pulled-up line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bkgd_sync <= '1;
    end else begin
      bkgd_sync <= {bkgd_sync[0], bkgd_in};
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_nxt = (bus.byte_count == 4'd0) ? ST_FIN : ST_CELL;
        end
      end
      ST_CELL: begin
        if (cell_end && bit_idx == 3'd7) begin
          state_nxt = ST_PUSH;
        end
      end
      ST_PUSH: begin
        if (!bus.full) begin
          state_nxt = (rem == 4'd1) ? ST_FIN : ST_CELL;
        end
      end
      ST_FIN: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath: byte counter, bit index, shift register and last pushed byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      last_byte <= '0;
    end else begin
      if (state == ST_IDLE && bus.start) begin
        rem     <= bus.byte_count;
        bit_idx <= '0;
      end
      if (sample) begin
        shreg <= {shreg[6:0], bkgd_s};
      end
      if (cell_end) begin
        bit_idx <= bit_idx + 3'd1;
      end
      if (push) begin
        rem       <= rem - 4'd1;
        last_byte <= shreg;
      end
    end
  end

  // Outputs decoded from registered state so reset releases BKGD in the same cycle;
  // put_byte shows the new byte in the push cycle and the held copy afterwards.
  always_comb begin
    bkgd_oe       = drive_low;
    bus.put_pulse = push;
    bus.put_byte  = push ? shreg : last_byte;
    bus.busy      = (state != ST_IDLE);
    bus.done      = (state == ST_FIN);
  end

endmodule
